// File: rtl/imem_loader.sv
// Boot-time byte-stream loader for the instruction memory.
// Holds the datapath in reset until the last word is written.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic        clock,
    input  logic        Reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        im_we,
    output logic [31:0] im_addr,
    output logic [31:0] im_wdata,
    output logic        cpu_reset,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        HDR_HI,
        HDR_LO,
        DATA,
        DONE
    } state_t;

    localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

    state_t      state;
    state_t      state_nx;
    logic [15:0] n_words;
    logic [15:0] n_full;
    logic [15:0] word_idx;
    logic [1:0]  byte_cnt;
    logic [23:0] asm_q;
    logic        xfer;
    logic        word_end;
    logic        last_word;
    logic        in_range;

    assign rx_ready  = Reset && (state != DONE);
    assign xfer      = rx_valid && rx_ready;
    assign n_full    = {n_words[15:8], rx_data};
    assign word_end  = xfer && (state == DATA) && (byte_cnt == 2'd3);
    assign last_word = (word_idx == n_words - 16'd1);
    assign in_range  = ({1'b0, word_idx} < DEPTH);

    always_ff @(posedge clock) begin
        if (!Reset) begin
            state <= HDR_HI;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            HDR_HI: begin
                if (xfer) state_nx = HDR_LO;
            end
            HDR_LO: begin
                if (xfer) state_nx = (n_full == 16'd0) ? DONE : DATA;
            end
            DATA: begin
                if (word_end && last_word) state_nx = DONE;
            end
            DONE: begin
                state_nx = DONE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!Reset) begin
            n_words   <= '0;
            word_idx  <= '0;
            byte_cnt  <= '0;
            asm_q     <= '0;
            im_we     <= 1'b0;
            im_addr   <= '0;
            im_wdata  <= '0;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            im_we <= 1'b0;
            if (xfer && state == HDR_HI) begin
                n_words[15:8] <= rx_data;
            end
            if (xfer && state == HDR_LO) begin
                n_words[7:0] <= rx_data;
                if ({1'b0, n_full} > DEPTH) err <= 1'b1;
            end
            if (xfer && state == DATA) begin
                byte_cnt <= byte_cnt + 2'd1;
                asm_q    <= {asm_q[15:0], rx_data};
            end
            // Overflowed words are still counted so the stream stays aligned
            if (word_end) begin
                im_wdata <= {asm_q, rx_data};
                im_addr  <= {14'd0, word_idx, 2'b00};
                im_we    <= in_range;
                word_idx <= word_idx + 16'd1;
            end
            if (state == DONE) begin
                cpu_reset <= 1'b0;
                done      <= 1'b1;
            end
        end
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that sits directly upstream of the single-cycle datapath's instruction memory. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. It writes them to consecutive word-aligned instruction-memory addresses and holds the datapath in reset until the whole program is loaded.

## Interface
- `ADDR_W`, default 8: word-address width; instruction memory depth is 2^ADDR_W words.
- `clock`  in  1: single clock, rising edge.
- `Reset`  in  1: synchronous, active-low reset.
- `rx_data`  in  8: incoming byte.
- `rx_valid`  in  1: `rx_data` valid.
- `rx_ready`  out  1: loader can accept a byte. Transfer occurs when `rx_valid & rx_ready` at a rising edge.
- `im_we`  out  1: instruction-memory write strobe, one-cycle pulse.
- `im_addr`  out  32: byte address of the write, always a multiple of 4.
- `im_wdata`  out  32: instruction word to write.
- `cpu_reset`  out  1: active-high reset to the datapath `Reset` input.
- `done`  out  1: load complete (sticky).
- `err`  out  1: header word count exceeded 2^ADDR_W (sticky).

## Operation
- Stream format:
  - 2-byte header: word count N, 16-bit, high byte first.
  - Then N×4 data bytes, each word most-significant byte first (first byte → bits [31:24]).
- FSM states and transitions:
  - HDR_HI: accept byte into N[15:8] → HDR_LO.
  - HDR_LO: accept byte into N[7:0]. If N==0 → DONE, otherwise → DATA. Set `err` if N > 2^ADDR_W.
  - DATA: shift bytes into a 24-bit assembly register with a 2-bit byte counter. On the 4th byte:
    - register `im_wdata` = {assembly[23:0], rx_data} and `im_addr` = word_idx<<2;
    - pulse `im_we` only if word_idx < 2^ADDR_W;
    - increment the 16-bit word_idx. When word_idx reaches N−1 on this transfer → DONE.
  - DONE: `rx_ready`=0 and all input is ignored. `cpu_reset` clears the cycle after entry; `done`=1 from that same cycle. Leave DONE only on reset.
- `rx_ready`=1 in HDR_HI, HDR_LO and DATA; no back-pressure during writes.
- Overflowed words (index ≥ 2^ADDR_W) are consumed but never written. `im_addr` never exceeds (2^ADDR_W−1)×4 while `im_we`=1.
- Reset (`Reset`=0 at an edge), including mid-load:
  - state → HDR_HI; byte counter, word_idx and N → 0;
  - outputs: `im_we`=0, `im_addr`=0, `im_wdata`=0, `cpu_reset`=1, `done`=0, `err`=0, `rx_ready`=0 during the reset cycle;
  - partially assembled words are discarded.

## Timing
- Throughput: 1 byte/cycle; one instruction word every 4 accepted bytes.
- Write latency: `im_we` is high for exactly the one cycle after the 4th byte's handshake, with `im_addr`/`im_wdata` valid in that cycle. A byte may be accepted in the same cycle as a write.
- Completion: the final `im_we` pulse coincides with the first DONE cycle; `cpu_reset` falls, and `done` rises, one cycle after that pulse. The datapath therefore never leaves reset before the last write lands.
- N==0: DONE is entered the cycle after the HDR_LO handshake; `cpu_reset` falls one cycle later.
- `err` is set the cycle after the HDR_LO handshake.
- `rx_valid` gaps stall assembly without state change; `rx_data` is ignored when `rx_valid`=0.

## Test plan
- Back-to-back load, ADDR_W=8, stream 00 02 20 08 00 05 01 09 50 20:
  - `im_we` pulse 1: addr 0x00000000, data 0x20080005;
  - `im_we` pulse 2: addr 0x00000004, data 0x01095020;
  - `cpu_reset` 1→0 and `done` 0→1 one cycle after pulse 2; `rx_ready`=0 afterwards; `err`=0.
- Header 00 00 → no `im_we`; `cpu_reset` falls and `done` rises two cycles after the 2nd header byte handshake.
- Same stream as the first scenario with random 0–3 cycle `rx_valid` gaps → identical write addresses, data and order; `cpu_reset` stays 1 until one cycle after the last write.
- ADDR_W=2, header 00 05, five words 0x11111111..0x55555555:
  - `err`=1 from the cycle after the header;
  - four writes at 0x0, 0x4, 0x8, 0xC;
  - 5th word consumed with no `im_we`; `done`=1 afterwards.
- `Reset` low after header 00 02 plus 6 data bytes, then a full reload of 00 01 AA BB CC DD:
  - during reset: all outputs at reset values, no spurious `im_we`;
  - after reload: a single write of 0xAABBCCDD at addr 0x0.
- After DONE, drive `rx_valid`=1 with 8 bytes → `rx_ready`=0 throughout; no `im_we`; `done`/`cpu_reset` unchanged.
